// File: rtl/fetch_ctrl_if.sv
// I-cache request bus for the fetch sequencer: SRAM-like req/addr_ok, then data_ok/rdata.
// master = fetch_ctrl side, slave = instruction cache side.
interface fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, arbitrates redirects, keeps one I-cache request in flight,
// and buffers one instruction toward Decode. Define FETCH_ALIGN_CHECK_EN to enable misaligned-fetch traps.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_valid,
  input  logic [31:0]        trap_pc,
  input  logic               mispred_valid,
  input  logic [31:0]        mispred_pc,
  input  logic               jump_valid,
  input  logic [31:0]        jump_pc,
  input  logic               predtake_valid,
  input  logic [31:0]        predtake_pc,
  input  logic               pipe_stall,
  fetch_ctrl_if.master       icache,
  output logic               inst_valid,
  output logic [31:0]        inst_pc,
  output logic [31:0]        inst_out,
  output logic               fetch_adel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        discard;

  logic        redirect;
  logic [31:0] target;
  logic        hold;
  logic        misaligned;
  logic        accept;
  logic        resp;
  logic        fill;

  assign redirect = trap_valid | mispred_valid | jump_valid | predtake_valid;

  // Fixed priority: older pipeline stages win over younger ones.
  always_comb begin
    target = predtake_pc;
    if (trap_valid)          target = trap_pc;
    else if (mispred_valid)  target = mispred_pc;
    else if (jump_valid)     target = jump_pc;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A full buffer that Decode refuses blocks the next request.
  assign hold   = inst_valid & pipe_stall;
  assign accept = icache.inst_req & icache.inst_addr_ok;
  assign resp   = (state == WAIT) & icache.inst_data_ok;
  assign fill   = resp & ~discard & ~redirect;

  assign icache.inst_req  = (state == REQ) & ~hold & ~misaligned;
  assign icache.inst_addr = pc;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      inst_valid <= 1'b0;
      inst_pc    <= 32'h0;
      inst_out   <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_adel <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;

        REQ: begin
          // An unaccepted request may be retargeted; an accepted one leaves with the old pc.
          if (redirect) pc <= target;
          if (accept) begin
            state   <= WAIT;
            discard <= redirect;
          end
        end

        WAIT: begin
          if (resp) begin
            discard <= 1'b0;
            state   <= REQ;
            if (redirect)      pc <= target;
            else if (!discard) pc <= pc + 32'd4;
          end else if (redirect) begin
            pc      <= target;
            discard <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Instruction buffer: a fill beats both flush and consume.
      if (fill) begin
        inst_valid <= 1'b1;
        inst_pc    <= pc;
        inst_out   <= icache.inst_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_adel <= 1'b0;
      end else if ((state == REQ) && !hold && misaligned && !redirect) begin
        inst_valid <= 1'b1;
        inst_pc    <= pc;
        inst_out   <= 32'h0;
        fetch_adel <= 1'b1;
`endif
      end else if (redirect && (state != IDLE)) begin
        inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_adel <= 1'b0;
`endif
      end else if (inst_valid && !pipe_stall) begin
        inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_adel <= 1'b0;
`endif
      end
    end
  end

`ifndef FETCH_ALIGN_CHECK_EN
  assign fetch_adel = 1'b0;
`endif

endmodule
